// File: rtl/pipeline_hazard_unit.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_unit
//
// Hazard and forwarding controller for the in-order pipeline
// (fetch, dec, op, ex, mem, wb, ...). The unit keeps a registered scoreboard
// of the destination registers of instructions past dec. From that scoreboard
// it:
//   - selects a forwarding source for each dec-stage operand, or
//   - inserts a RAW stall when the producer's result is not ready yet,
// and it also handles taken-branch flushes and multi-cycle EX stalls.
// A saturating counter of RAW-stall cycles is kept for performance
// measurement.
//
// Scoreboard slot k mirrors pipeline stage k+2:
//   slot 0 = op, slot 1 = ex, slot 2 = mem, ...
//
// Ports
//   clk             clock
//   reset           asynchronous, active-high reset
//   rs1_dec         dec-stage source register 1 (rs1_used_dec: it is read)
//   rs2_dec         dec-stage source register 2 (rs2_used_dec: it is read)
//   rd_dec          dec-stage destination register
//   rd_used_dec     dec instruction writes rd from the ALU
//   rd_memory_dec   dec instruction writes rd from memory (load)
//   branch_taken_ex taken branch/jump resolved in EX
//   ex_busy         multi-cycle EX unit has not finished
//   stall_clr       synchronous clear of stall_cycles
//   stage_ena       per-stage register enable (bit 0 = fetch, bit 1 = dec)
//   stage_nop       stage i hands a bubble to stage i+1
//   fwd_sel_rs1/2   0 = register file, k+1 = forward from slot k
//   stall_cycles    saturating count of RAW-stall cycles
//
// There are no handshakes. Every output is a combinational function of the
// scoreboard and the dec-stage inputs. fwd_sel_* is driven in every cycle;
// the consumer qualifies it with stage_ena[1].
// ---------------------------------------------------------------------------
module pipeline_hazard_unit #(
    parameter int REG_AW        = 5,
    parameter int PIPE_DEPTH    = 4,
    parameter int EX_SLOT       = 1,
    parameter int FWD_ENABLE    = 1,
    parameter int ALU_FWD_SLOT  = 1,
    parameter int LOAD_FWD_SLOT = 2,
    parameter int CNT_W         = 16,
    localparam int NSTAGE       = PIPE_DEPTH + 2,
    localparam int FW           = $clog2(PIPE_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1_dec,
    input  logic              rs1_used_dec,
    input  logic [REG_AW-1:0] rs2_dec,
    input  logic              rs2_used_dec,
    input  logic [REG_AW-1:0] rd_dec,
    input  logic              rd_used_dec,
    input  logic              rd_memory_dec,
    input  logic              branch_taken_ex,
    input  logic              ex_busy,
    input  logic              stall_clr,
    output logic [NSTAGE-1:0] stage_ena,
    output logic [NSTAGE-1:0] stage_nop,
    output logic [FW-1:0]     fwd_sel_rs1,
    output logic [FW-1:0]     fwd_sel_rs2,
    output logic [CNT_W-1:0]  stall_cycles
);

    // Effective pipeline condition for this cycle, highest priority first:
    // busy > branch > raw > normal.
    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_RAW    = 2'd1,
        MODE_BRANCH = 2'd2,
        MODE_BUSY   = 2'd3
    } mode_e;

    // ---------------------------------------------------------------------
    // Scoreboard state
    // ---------------------------------------------------------------------
    logic [PIPE_DEPTH-1:0]             sb_valid;
    logic [PIPE_DEPTH-1:0]             sb_load;
    logic [PIPE_DEPTH-1:0][REG_AW-1:0] sb_rd;

    logic [PIPE_DEPTH-1:0]             nxt_valid;
    logic [PIPE_DEPTH-1:0]             nxt_load;
    logic [PIPE_DEPTH-1:0][REG_AW-1:0] nxt_rd;

    // Lookup results per source operand
    logic          rs1_hit;
    logic          rs1_ok;
    logic [FW-1:0] rs1_sel;
    logic          rs2_hit;
    logic          rs2_ok;
    logic [FW-1:0] rs2_sel;

    logic  raw_stall;
    logic  dec_writes;
    mode_e mode;

    // A result in slot k can be forwarded once the producer has advanced
    // far enough. Loads produce their data later than ALU operations.
    function automatic logic slot_fwd_ok(input int k, input logic is_load);
        return (FWD_ENABLE != 0) &&
               (k >= (is_load ? LOAD_FWD_SLOT : ALU_FWD_SLOT));
    endfunction

    // Returns {hit, forwardable, slot+1} for the youngest matching slot.
    // The loop runs from oldest to youngest, so the last match written
    // (lowest k) wins.
    function automatic logic [FW+1:0] lookup(
        input logic [REG_AW-1:0]             rs,
        input logic                          used,
        input logic [PIPE_DEPTH-1:0]         v,
        input logic [PIPE_DEPTH-1:0]         ld,
        input logic [PIPE_DEPTH-1:0][REG_AW-1:0] rd
    );
        logic          hit;
        logic          ok;
        logic [FW-1:0] sel;
        hit = 1'b0;
        ok  = 1'b0;
        sel = '0;
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            if (used && (rs != '0) && v[k] && (rd[k] == rs)) begin
                hit = 1'b1;
                ok  = slot_fwd_ok(k, ld[k]);
                sel = FW'(k + 1);
            end
        end
        return {hit, ok, sel};
    endfunction

    // ---------------------------------------------------------------------
    // Dependency lookup and forwarding selection
    // ---------------------------------------------------------------------
    always_comb begin
        {rs1_hit, rs1_ok, rs1_sel} = lookup(rs1_dec, rs1_used_dec,
                                            sb_valid, sb_load, sb_rd);
        {rs2_hit, rs2_ok, rs2_sel} = lookup(rs2_dec, rs2_used_dec,
                                            sb_valid, sb_load, sb_rd);

        // A match whose data is not ready yet must stall. In that case the
        // select falls back to 0, because the value is not usable.
        fwd_sel_rs1 = rs1_ok ? rs1_sel : '0;
        fwd_sel_rs2 = rs2_ok ? rs2_sel : '0;
        raw_stall   = (rs1_hit && !rs1_ok) || (rs2_hit && !rs2_ok);
    end

    // Register 0 is hard-wired to zero, so it is never tracked.
    assign dec_writes = (rd_used_dec || rd_memory_dec) && (rd_dec != '0);

    // ---------------------------------------------------------------------
    // Condition priority
    // ---------------------------------------------------------------------
    always_comb begin
        mode = MODE_NORMAL;
        if (ex_busy) begin
            // A branch resolving in a stalled EX is not final yet.
            mode = MODE_BUSY;
        end else if (branch_taken_ex) begin
            // The instruction that would stall is flushed anyway.
            mode = MODE_BRANCH;
        end else if (raw_stall) begin
            mode = MODE_RAW;
        end
    end

    // ---------------------------------------------------------------------
    // Stage enables and bubbles
    // ---------------------------------------------------------------------
    always_comb begin
        stage_ena = '1;
        stage_nop = '0;
        unique case (mode)
            MODE_RAW: begin
                // Hold fetch and dec; send a bubble into op.
                stage_ena[0] = 1'b0;
                stage_ena[1] = 1'b0;
                stage_nop[1] = 1'b1;
            end
            MODE_BRANCH: begin
                // Squash the wrong-path instructions in fetch, dec and op.
                stage_nop[2:0] = 3'b111;
            end
            MODE_BUSY: begin
                // Freeze everything up to and including EX. The stages
                // behind EX keep draining, so EX sends a bubble forward.
                for (int i = 0; i < NSTAGE; i++) begin
                    if (i <= EX_SLOT + 2) begin
                        stage_ena[i] = 1'b0;
                    end
                end
                stage_nop[EX_SLOT+2] = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Scoreboard next state
    // ---------------------------------------------------------------------
    always_comb begin
        nxt_valid = '0;
        nxt_load  = '0;
        nxt_rd    = '0;

        // Baseline: advance one slot and accept the dec instruction.
        nxt_valid[0] = dec_writes;
        nxt_load[0]  = dec_writes && rd_memory_dec;
        nxt_rd[0]    = dec_writes ? rd_dec : '0;
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            nxt_valid[k] = sb_valid[k-1];
            nxt_load[k]  = sb_load[k-1];
            nxt_rd[k]    = sb_rd[k-1];
        end

        unique case (mode)
            MODE_RAW: begin
                // dec is held, so op receives a bubble.
                nxt_valid[0] = 1'b0;
                nxt_load[0]  = 1'b0;
                nxt_rd[0]    = '0;
            end
            MODE_BRANCH: begin
                // Everything younger than the branch is squashed.
                for (int k = 0; k < PIPE_DEPTH; k++) begin
                    if (k <= EX_SLOT) begin
                        nxt_valid[k] = 1'b0;
                        nxt_load[k]  = 1'b0;
                        nxt_rd[k]    = '0;
                    end
                end
            end
            MODE_BUSY: begin
                // The frozen stages keep their entries. The slot after EX
                // takes the bubble, and older slots continue to drain.
                for (int k = 0; k < PIPE_DEPTH; k++) begin
                    if (k <= EX_SLOT) begin
                        nxt_valid[k] = sb_valid[k];
                        nxt_load[k]  = sb_load[k];
                        nxt_rd[k]    = sb_rd[k];
                    end else if (k == EX_SLOT + 1) begin
                        nxt_valid[k] = 1'b0;
                        nxt_load[k]  = 1'b0;
                        nxt_rd[k]    = '0;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_valid <= '0;
            sb_load  <= '0;
            sb_rd    <= '0;
        end else begin
            sb_valid <= nxt_valid;
            sb_load  <= nxt_load;
            sb_rd    <= nxt_rd;
        end
    end

    // Only stalls that actually take effect are counted. A RAW condition
    // hidden behind busy or branch does not count. A clear takes priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall_clr) begin
            stall_cycles <= '0;
        end else if ((mode == MODE_RAW) && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// ---------------------------------------------------------------------------
// Testbench for pipeline_hazard_unit.
// dut   : default parameters (forwarding on, 16-bit counter)
// dut_b : forwarding off, 4-bit counter, so that saturation is reached in a
//         few dozen cycles
// Each cycle, the inputs are driven 1 ns after the rising edge, and the
// expected output vector is pushed to exp_q. Outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_unit;

    localparam int NS = 6;
    localparam int FW = 3;
    localparam int OW = 2 * NS + 2 * FW;

    localparam logic [1:0] M_NORM = 2'd0;
    localparam logic [1:0] M_RAW  = 2'd1;
    localparam logic [1:0] M_BR   = 2'd2;
    localparam logic [1:0] M_BUSY = 2'd3;

    localparam logic [NS-1:0] ENA_ALL  = 6'b111111;
    localparam logic [NS-1:0] ENA_RAW  = 6'b111100;
    localparam logic [NS-1:0] ENA_BUSY = 6'b110000;
    localparam logic [NS-1:0] NOP_NONE = 6'b000000;
    localparam logic [NS-1:0] NOP_RAW  = 6'b000010;
    localparam logic [NS-1:0] NOP_BR   = 6'b000111;
    localparam logic [NS-1:0] NOP_BUSY = 6'b001000;

    typedef struct packed {
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       alu;
        logic       ld;
        logic       br;
        logic       busy;
        logic       clr;
        logic [1:0] mode;
        logic [2:0] f1;
        logic [2:0] f2;
    } stim_t;

    // ---------------- clock / reset / signals ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [4:0] rs1_dec, rs2_dec, rd_dec;
    logic rs1_used_dec, rs2_used_dec, rd_used_dec, rd_memory_dec;
    logic branch_taken_ex, ex_busy, stall_clr;
    logic [NS-1:0] stage_ena, stage_nop;
    logic [FW-1:0] fwd_sel_rs1, fwd_sel_rs2;
    logic [15:0] stall_cycles;

    logic [4:0] b_rs1_dec, b_rs2_dec, b_rd_dec;
    logic b_rs1_used, b_rs2_used, b_rd_used, b_rd_memory;
    logic b_branch, b_busy, b_clr;
    logic [NS-1:0] b_stage_ena, b_stage_nop;
    logic [FW-1:0] b_fwd_sel_rs1, b_fwd_sel_rs2;
    logic [3:0] b_stall_cycles;

    pipeline_hazard_unit #(.FWD_ENABLE(1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .rs1_dec(rs1_dec), .rs1_used_dec(rs1_used_dec),
        .rs2_dec(rs2_dec), .rs2_used_dec(rs2_used_dec),
        .rd_dec(rd_dec), .rd_used_dec(rd_used_dec),
        .rd_memory_dec(rd_memory_dec),
        .branch_taken_ex(branch_taken_ex), .ex_busy(ex_busy),
        .stall_clr(stall_clr),
        .stage_ena(stage_ena), .stage_nop(stage_nop),
        .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2),
        .stall_cycles(stall_cycles)
    );

    pipeline_hazard_unit #(.FWD_ENABLE(0), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset),
        .rs1_dec(b_rs1_dec), .rs1_used_dec(b_rs1_used),
        .rs2_dec(b_rs2_dec), .rs2_used_dec(b_rs2_used),
        .rd_dec(b_rd_dec), .rd_used_dec(b_rd_used),
        .rd_memory_dec(b_rd_memory),
        .branch_taken_ex(b_branch), .ex_busy(b_busy),
        .stall_clr(b_clr),
        .stage_ena(b_stage_ena), .stage_nop(b_stage_nop),
        .fwd_sel_rs1(b_fwd_sel_rs1), .fwd_sel_rs2(b_fwd_sel_rs2),
        .stall_cycles(b_stall_cycles)
    );

    // ---------------- scoreboard state ----------------
    logic [OW-1:0] exp_q[$];
    int n_tests;
    int n_fail;
    int exp_cnt;
    int exp_b_cnt;

    function automatic logic [OW-1:0] mk_exp(input logic [1:0] mode,
                                             input logic [FW-1:0] f1,
                                             input logic [FW-1:0] f2);
        logic [NS-1:0] e;
        logic [NS-1:0] n;
        case (mode)
            M_RAW:   begin e = ENA_RAW;  n = NOP_RAW;  end
            M_BR:    begin e = ENA_ALL;  n = NOP_BR;   end
            M_BUSY:  begin e = ENA_BUSY; n = NOP_BUSY; end
            default: begin e = ENA_ALL;  n = NOP_NONE; end
        endcase
        return {e, n, f1, f2};
    endfunction

    function automatic stim_t st(input int rs1, input int u1, input int rs2,
                                 input int u2, input int rd, input int alu,
                                 input int ld, input int br, input int busy,
                                 input int clr, input logic [1:0] mode,
                                 input int f1, input int f2);
        stim_t s;
        s.rs1  = 5'(rs1);
        s.u1   = 1'(u1);
        s.rs2  = 5'(rs2);
        s.u2   = 1'(u2);
        s.rd   = 5'(rd);
        s.alu  = 1'(alu);
        s.ld   = 1'(ld);
        s.br   = 1'(br);
        s.busy = 1'(busy);
        s.clr  = 1'(clr);
        s.mode = mode;
        s.f1   = 3'(f1);
        s.f2   = 3'(f2);
        return s;
    endfunction

    function automatic logic [OW-1:0] obs_a();
        return {stage_ena, stage_nop, fwd_sel_rs1, fwd_sel_rs2};
    endfunction

    function automatic logic [OW-1:0] obs_b();
        return {b_stage_ena, b_stage_nop, b_fwd_sel_rs1, b_fwd_sel_rs2};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply_a(input stim_t s);
        rs1_dec = s.rs1;  rs1_used_dec = s.u1;
        rs2_dec = s.rs2;  rs2_used_dec = s.u2;
        rd_dec = s.rd;    rd_used_dec = s.alu;  rd_memory_dec = s.ld;
        branch_taken_ex = s.br;  ex_busy = s.busy;  stall_clr = s.clr;
    endtask

    task automatic apply_b(input stim_t s);
        b_rs1_dec = s.rs1;  b_rs1_used = s.u1;
        b_rs2_dec = s.rs2;  b_rs2_used = s.u2;
        b_rd_dec = s.rd;    b_rd_used = s.alu;  b_rd_memory = s.ld;
        b_branch = s.br;    b_busy = s.busy;    b_clr = s.clr;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_a();
        for (int i = 0; i < 5; i++) begin
            apply_a(st(0,0,0,0,0,0,0,0,0,0,M_NORM,0,0));
            next_cycle();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        stim_t tbl[$];
        logic [OW-1:0] want;
        tbl.push_back(st(0,0,0,0,0,0,0,0,0,0,M_NORM,0,0));
        tbl.push_back(st(0,0,0,0,5,1,0,0,0,0,M_NORM,0,0));
        tbl.push_back(st(5,1,0,0,6,1,0,0,0,0,M_RAW ,0,0));
        tbl.push_back(st(5,1,0,0,6,1,0,0,0,0,M_NORM,2,0));
        tbl.push_back(st(0,0,0,0,8,1,0,0,0,0,M_NORM,0,0));
        foreach (tbl[i]) begin
            apply_a(tbl[i]);
            exp_q.push_back(mk_exp(tbl[i].mode, tbl[i].f1, tbl[i].f2));
            @(negedge clk);
            want = exp_q.pop_front();
            n_tests++;
            if (obs_a() !== want) begin
                n_fail++;
                $display("FAIL reset_pre[%0d] obs: got %b want %b", i, obs_a(), want);
            end
            n_tests++;
            if (stall_cycles !== 16'(exp_cnt)) begin
                n_fail++;
                $display("FAIL reset_pre[%0d] cnt: got %0d want %0d", i, stall_cycles, exp_cnt);
            end
            if (tbl[i].mode == M_RAW) exp_cnt++;
            next_cycle();
        end
        // Slots now hold 8, 6, -, 5 and the counter is 1. A reset pulse in
        // the middle of the cycle must forget all of it.
        reset = 1'b1;
        #2;
        reset = 1'b0;
        exp_cnt = 0;
        apply_a(st(5,1,6,1,0,0,0,0,0,0,M_NORM,0,0));
        exp_q.push_back(mk_exp(M_NORM, 0, 0));
        @(negedge clk);
        want = exp_q.pop_front();
        n_tests++;
        if (obs_a() !== want) begin
            n_fail++;
            $display("FAIL reset_post obs: got %b want %b", obs_a(), want);
        end
        n_tests++;
        if (stall_cycles !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_post cnt: got %0d want 0", stall_cycles);
        end
        next_cycle();
    endtask

    task automatic test_alu_fwd();
        stim_t tbl[$];
        logic [OW-1:0] want;
        flush_a();
        tbl.push_back(st(0,0,0,0,5,1,0,0,0,0,M_NORM,0,0));
        tbl.push_back(st(5,1,0,0,0,0,0,0,0,0,M_RAW ,0,0));
        tbl.push_back(st(5,1,0,0,0,0,0,0,0,0,M_NORM,2,0));
        tbl.push_back(st(5,1,5,1,0,0,0,0,0,0,M_NORM,3,3));
        tbl.push_back(st(0,0,0,0,4,1,0,0,0,0,M_NORM,0,0));
        tbl.push_back(st(0,0,0,0,4,1,0,0,0,0,M_NORM,0,0));
        tbl.push_back(st(0,0,0,0,0,0,0,0,0,0,M_NORM,0,0));
        tbl.push_back(st(0,0,4,1,0,0,0,0,0,0,M_NORM,0,2));
        foreach (tbl[i]) begin
            apply_a(tbl[i]);
            exp_q.push_back(mk_exp(tbl[i].mode, tbl[i].f1, tbl[i].f2));
            @(negedge clk);
            want = exp_q.pop_front();
            n_tests++;
            if (obs_a() !== want) begin
                n_fail++;
                $display("FAIL alu_fwd[%0d] obs: got %b want %b", i, obs_a(), want);
            end
            n_tests++;
            if (stall_cycles !== 16'(exp_cnt)) begin
                n_fail++;
                $display("FAIL alu_fwd[%0d] cnt: got %0d want %0d", i, stall_cycles, exp_cnt);
            end
            if (tbl[i].mode == M_RAW) exp_cnt++;
            next_cycle();
        end
    endtask

    task automatic test_load_fwd();
        stim_t tbl[$];
        logic [OW-1:0] want;
        flush_a();
        tbl.push_back(st(0,0,0,0,7,0,1,0,0,0,M_NORM,0,0));
        tbl.push_back(st(0,0,7,1,0,0,0,0,0,0,M_RAW ,0,0));
        tbl.push_back(st(0,0,7,1,0,0,0,0,0,0,M_RAW ,0,0));
        tbl.push_back(st(0,0,7,1,0,0,0,0,0,0,M_NORM,0,3));
        foreach (tbl[i]) begin
            apply_a(tbl[i]);
            exp_q.push_back(mk_exp(tbl[i].mode, tbl[i].f1, tbl[i].f2));
            @(negedge clk);
            want = exp_q.pop_front();
            n_tests++;
            if (obs_a() !== want) begin
                n_fail++;
                $display("FAIL load_fwd[%0d] obs: got %b want %b", i, obs_a(), want);
            end
            n_tests++;
            if (stall_cycles !== 16'(exp_cnt)) begin
                n_fail++;
                $display("FAIL load_fwd[%0d] cnt: got %0d want %0d", i, stall_cycles, exp_cnt);
            end
            if (tbl[i].mode == M_RAW) exp_cnt++;
            next_cycle();
        end
    endtask

    task automatic test_zero_reg();
        stim_t tbl[$];
        logic [OW-1:0] want;
        flush_a();
        tbl.push_back(st(0,0,0,0,0,1,0,0,0,0,M_NORM,0,0));
        tbl.push_back(st(0,0,0,0,0,0,1,0,0,0,M_NORM,0,0));
        tbl.push_back(st(0,1,0,1,0,0,0,0,0,0,M_NORM,0,0));
        tbl.push_back(st(0,1,0,1,0,0,0,0,0,0,M_NORM,0,0));
        foreach (tbl[i]) begin
            apply_a(tbl[i]);
            exp_q.push_back(mk_exp(tbl[i].mode, tbl[i].f1, tbl[i].f2));
            @(negedge clk);
            want = exp_q.pop_front();
            n_tests++;
            if (obs_a() !== want) begin
                n_fail++;
                $display("FAIL zero_reg[%0d] obs: got %b want %b", i, obs_a(), want);
            end
            n_tests++;
            if (stall_cycles !== 16'(exp_cnt)) begin
                n_fail++;
                $display("FAIL zero_reg[%0d] cnt: got %0d want %0d", i, stall_cycles, exp_cnt);
            end
            if (tbl[i].mode == M_RAW) exp_cnt++;
            next_cycle();
        end
    endtask

    task automatic test_branch();
        stim_t tbl[$];
        logic [OW-1:0] want;
        flush_a();
        tbl.push_back(st(0,0,0,0,11,1,0,0,0,0,M_NORM,0,0));
        tbl.push_back(st(0,0,0,0, 9,1,0,0,0,0,M_NORM,0,0));
        // This RAW on slot 0 is overridden by the branch.
        tbl.push_back(st(9,1,0,0,10,1,0,1,0,0,M_BR  ,0,0));
        tbl.push_back(st(9,1,10,1,0,0,0,0,0,0,M_NORM,0,0));
        tbl.push_back(st(11,1,0,0,0,0,0,0,0,0,M_NORM,4,0));
        foreach (tbl[i]) begin
            apply_a(tbl[i]);
            exp_q.push_back(mk_exp(tbl[i].mode, tbl[i].f1, tbl[i].f2));
            @(negedge clk);
            want = exp_q.pop_front();
            n_tests++;
            if (obs_a() !== want) begin
                n_fail++;
                $display("FAIL branch[%0d] obs: got %b want %b", i, obs_a(), want);
            end
            n_tests++;
            if (stall_cycles !== 16'(exp_cnt)) begin
                n_fail++;
                $display("FAIL branch[%0d] cnt: got %0d want %0d", i, stall_cycles, exp_cnt);
            end
            if (tbl[i].mode == M_RAW) exp_cnt++;
            next_cycle();
        end
    endtask

    task automatic test_ex_busy();
        stim_t tbl[$];
        logic [OW-1:0] want;
        flush_a();
        tbl.push_back(st(0,0,0,0,12,1,0,0,0,0,M_NORM,0,0));
        tbl.push_back(st(0,0,0,0, 0,0,0,0,0,0,M_NORM,0,0));
        tbl.push_back(st(0,0,0,0,13,1,0,0,0,0,M_NORM,0,0));
        // 12 sits in slot 2 and 13 in slot 0 when busy begins.
        tbl.push_back(st(12,1,13,1,0,0,0,0,1,0,M_BUSY,3,0));
        tbl.push_back(st(12,1,13,1,0,0,0,0,1,0,M_BUSY,4,0));
        tbl.push_back(st(12,1,13,1,0,0,0,1,1,0,M_BUSY,0,0));
        tbl.push_back(st(12,1,13,1,0,0,0,0,0,0,M_RAW ,0,0));
        tbl.push_back(st(12,1,13,1,0,0,0,0,0,0,M_NORM,0,2));
        foreach (tbl[i]) begin
            apply_a(tbl[i]);
            exp_q.push_back(mk_exp(tbl[i].mode, tbl[i].f1, tbl[i].f2));
            @(negedge clk);
            want = exp_q.pop_front();
            n_tests++;
            if (obs_a() !== want) begin
                n_fail++;
                $display("FAIL ex_busy[%0d] obs: got %b want %b", i, obs_a(), want);
            end
            n_tests++;
            if (stall_cycles !== 16'(exp_cnt)) begin
                n_fail++;
                $display("FAIL ex_busy[%0d] cnt: got %0d want %0d", i, stall_cycles, exp_cnt);
            end
            if (tbl[i].mode == M_RAW) exp_cnt++;
            next_cycle();
        end
    endtask

    task automatic test_no_fwd();
        stim_t tbl[$];
        logic [OW-1:0] want;
        tbl.push_back(st(0,0,0,0,5,1,0,0,0,0,M_NORM,0,0));
        for (int i = 0; i < 4; i++) begin
            tbl.push_back(st(5,1,0,0,0,0,0,0,0,0,M_RAW,0,0));
        end
        tbl.push_back(st(5,1,0,0,0,0,0,0,0,0,M_NORM,0,0));
        foreach (tbl[i]) begin
            apply_b(tbl[i]);
            exp_q.push_back(mk_exp(tbl[i].mode, tbl[i].f1, tbl[i].f2));
            @(negedge clk);
            want = exp_q.pop_front();
            n_tests++;
            if (obs_b() !== want) begin
                n_fail++;
                $display("FAIL no_fwd[%0d] obs: got %b want %b", i, obs_b(), want);
            end
            n_tests++;
            if (b_stall_cycles !== 4'(exp_b_cnt)) begin
                n_fail++;
                $display("FAIL no_fwd[%0d] cnt: got %0d want %0d", i, b_stall_cycles, exp_b_cnt);
            end
            if (tbl[i].mode == M_RAW && exp_b_cnt < 15) exp_b_cnt++;
            next_cycle();
        end
    endtask

    task automatic test_counter_sat();
        stim_t tbl[$];
        logic [OW-1:0] want;
        // "rs1 = 5, rd = 5" repeated: one issue, then 4 stall cycles.
        for (int t = 1; t <= 28; t++) begin
            tbl.push_back(st(5,1,0,0,5,1,0,0,0, (t == 27) ? 1 : 0,
                             (t % 5 == 1) ? M_NORM : M_RAW, 0, 0));
        end
        foreach (tbl[i]) begin
            apply_b(tbl[i]);
            exp_q.push_back(mk_exp(tbl[i].mode, tbl[i].f1, tbl[i].f2));
            @(negedge clk);
            want = exp_q.pop_front();
            n_tests++;
            if (obs_b() !== want) begin
                n_fail++;
                $display("FAIL counter_sat[%0d] obs: got %b want %b", i, obs_b(), want);
            end
            n_tests++;
            if (b_stall_cycles !== 4'(exp_b_cnt)) begin
                n_fail++;
                $display("FAIL counter_sat[%0d] cnt: got %0d want %0d", i, b_stall_cycles, exp_b_cnt);
            end
            if (tbl[i].clr) exp_b_cnt = 0;
            else if (tbl[i].mode == M_RAW && exp_b_cnt < 15) exp_b_cnt++;
            next_cycle();
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_tests = 0;
        n_fail = 0;
        exp_cnt = 0;
        exp_b_cnt = 0;
        reset = 1'b1;
        apply_a(st(0,0,0,0,0,0,0,0,0,0,M_NORM,0,0));
        apply_b(st(0,0,0,0,0,0,0,0,0,0,M_NORM,0,0));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_alu_fwd();
        test_load_fwd();
        test_zero_reg();
        test_branch();
        test_ex_busy();
        test_no_fwd();
        test_counter_sat();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
